// File: rtl/fric_pkg.sv
// Shared definitions for the parametrised FRIC register-slave client:
// opcode nibbles, inbound/outbound state encodings and a counter-width helper.
package fric_pkg;

    // Command and reply opcodes carried in the upper nibble of a header byte
    localparam logic [3:0] WR_CMD = 4'h2;
    localparam logic [3:0] RD_CMD = 4'h3;
    localparam logic [3:0] WR_ACK = 4'h4;
    localparam logic [3:0] RD_ACK = 4'h5;
    localparam logic [3:0] RD_ERR = 4'h7;

    // Inbound (command decode) states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ADR,
        RX_WDAT
    } rx_state_e;

    // Outbound (reply serializer) states
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_RWAIT,
        TX_HDR,
        TX_ADR,
        TX_DAT
    } tx_state_e;

    // Byte counters must index up to max(ABYTES, DBYTES)-1; never narrower than 1 bit
    function automatic int cnt_width(input int abytes, input int dbytes);
        int m;
        m = (abytes > dbytes) ? abytes : dbytes;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fric_slv_tx.sv
// Reply serializer for fric_client_slave_p: outbound FSM, read-data wait with
// timeout, and the fric_out byte mux (0x00 whenever no reply byte is due).
module fric_slv_tx
    import fric_pkg::*;
#(
    parameter int ABYTES     = 1,
    parameter int DBYTES     = 2,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_wr,
    input  logic                  start_rd,
    input  logic [3:0]            port,
    input  logic [8*ABYTES-1:0]   addr,
    input  logic [8*DBYTES-1:0]   rdat,
    input  logic                  rvld,
    output logic [7:0]            fric_out,
    output logic                  tx_idle
);

    localparam int            CW       = cnt_width(ABYTES, DBYTES);
    localparam logic [CW-1:0] A_LAST   = CW'(ABYTES - 1);
    localparam logic [CW-1:0] D_LAST   = CW'(DBYTES - 1);
    localparam logic [7:0]    TMO_LAST = 8'(RD_TIMEOUT - 1);

    tx_state_e            state;
    tx_state_e            state_nxt;
    logic [CW-1:0]        cnt;
    logic [7:0]           tmo;
    logic [3:0]           op;
    logic [8*DBYTES-1:0]  rdat_q;
    logic                 timeout;

    // Last RWAIT cycle allowed without rvld has just elapsed
    assign timeout = (state == TX_RWAIT) && !rvld && (tmo == TMO_LAST);
    assign tx_idle = (state == TX_IDLE);

    // Outbound state register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst) state <= TX_IDLE;
        else      state <= state_nxt;
    end

    // Outbound next-state: wait for read data, then header, address, optional data
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt; no latch is inferred.
        state_nxt = state;
        case (state)
            TX_IDLE: begin
                if (start_wr)      state_nxt = TX_HDR;
                else if (start_rd) state_nxt = TX_RWAIT;
            end
            TX_RWAIT: if (rvld || timeout) state_nxt = TX_HDR;
            TX_HDR:   state_nxt = TX_ADR;
            TX_ADR: begin
                if (cnt == A_LAST) state_nxt = (op == RD_ACK) ? TX_DAT : TX_IDLE;
            end
            TX_DAT:   if (cnt == D_LAST) state_nxt = TX_IDLE;
            default:  state_nxt = TX_IDLE;
        endcase
    end

    // Byte counter, RWAIT timer and reply opcode selection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            tmo <= '0;
            op  <= '0;
        end else begin
            cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
            tmo <= (state == TX_RWAIT && state_nxt == TX_RWAIT) ? tmo + 8'd1 : 8'd0;
            if (state == TX_IDLE && start_wr) begin
                op <= WR_ACK;
            end else if (state == TX_RWAIT) begin
                if (rvld)         op <= RD_ACK;
                else if (timeout) op <= RD_ERR;
            end
        end
    end

    // Read data capture on the first rvld seen while waiting
    always_ff @(posedge clk) begin
        // NOTE: rdat_q has no reset; it is only ever read after being loaded here.
        if (state == TX_RWAIT && rvld) rdat_q <= rdat;
    end

    // fric_out byte mux: header, then address bytes, then data bytes, LSB first
    always_comb begin
        fric_out = 8'h00;
        case (state)
            TX_HDR: fric_out = {op, port};
            TX_ADR: begin
                for (int i = 0; i < ABYTES; i++)
                    if (cnt == CW'(i)) fric_out = addr[8*i +: 8];
            end
            TX_DAT: begin
                for (int i = 0; i < DBYTES; i++)
                    if (cnt == CW'(i)) fric_out = rdat_q[8*i +: 8];
            end
            default: fric_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/fric_client_slave_p.sv
// Parametrised FRIC register-slave client. Decodes write/read command frames
// from the registered inbound byte stream, drives the local register strobes
// and hands replies to fric_slv_tx.
// Compile-time option FRIC_SLV_PORT_FILTER_EN: answer only headers whose port
// nibble equals PORT_ID; other headers are skipped silently.
module fric_client_slave_p
    import fric_pkg::*;
#(
    parameter int         ABYTES     = 1,
    parameter int         DBYTES     = 2,
    parameter logic [3:0] PORT_ID    = 4'h0,
    parameter int         RD_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           fric_in,
    output logic [7:0]           fric_out,
    output logic [8*ABYTES-1:0]  addr,
    output logic [8*DBYTES-1:0]  wdat,
    output logic                 wstb,
    output logic                 rstb,
    input  logic [8*DBYTES-1:0]  rdat,
    input  logic                 rvld,
    output logic                 busy,
    output logic                 drop
);

`ifdef FRIC_SLV_PORT_FILTER_EN
    localparam bit PORT_FILTER = 1'b1;
`else
    localparam bit PORT_FILTER = 1'b0;
`endif

    localparam int            CW     = cnt_width(ABYTES, DBYTES);
    localparam logic [CW-1:0] A_LAST = CW'(ABYTES - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DBYTES - 1);

    rx_state_e      rx_state;
    rx_state_e      rx_nxt;
    logic [CW-1:0]  rx_cnt;
    logic [7:0]     fric_inr;
    logic [3:0]     port_q;
    logic           is_rd;
    logic           skip;
    logic           wr_done;
    logic           tx_idle;

    logic           is_hdr;
    logic           port_ok;
    logic           hdr_take;
    logic           drop_nxt;
    logic           adr_last;
    logic           wdat_last;
    logic           start_wr;
    logic           start_rd;

    // Header classification and frame-boundary decode from the registered byte
    always_comb begin
        is_hdr    = (fric_inr[7:4] == WR_CMD) || (fric_inr[7:4] == RD_CMD);
        port_ok   = !PORT_FILTER || (fric_inr[3:0] == PORT_ID);
        // A foreign-port header is walked through silently; our own needs an idle replier
        hdr_take  = (rx_state == RX_IDLE) && is_hdr && (!port_ok || tx_idle);
        drop_nxt  = (rx_state == RX_IDLE) && is_hdr && port_ok && !tx_idle;
        adr_last  = (rx_state == RX_ADR)  && (rx_cnt == A_LAST);
        wdat_last = (rx_state == RX_WDAT) && (rx_cnt == D_LAST);
        start_wr  = adr_last && !is_rd && !skip;
        start_rd  = adr_last &&  is_rd && !skip;
    end

    // Inbound state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_state <= RX_IDLE;
        else      rx_state <= rx_nxt;
    end

    // Inbound next-state: header, ABYTES address bytes, DBYTES data bytes for writes
    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            RX_IDLE: if (hdr_take) rx_nxt = RX_ADR;
            RX_ADR:  if (rx_cnt == A_LAST) rx_nxt = is_rd ? RX_IDLE : RX_WDAT;
            RX_WDAT: if (rx_cnt == D_LAST) rx_nxt = RX_IDLE;
            default: rx_nxt = RX_IDLE;
        endcase
    end

    // Input register, byte capture, frame attributes and strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fric_inr <= '0;
            rx_cnt   <= '0;
            port_q   <= '0;
            is_rd    <= 1'b0;
            skip     <= 1'b0;
            addr     <= '0;
            wdat     <= '0;
            wr_done  <= 1'b0;
            wstb     <= 1'b0;
            rstb     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            fric_inr <= fric_in;
            rx_cnt   <= (rx_nxt != rx_state) ? '0 : rx_cnt + 1'b1;
            if (hdr_take) begin
                is_rd <= (fric_inr[7:4] == RD_CMD);
                skip  <= !port_ok;
                // A skipped header must not disturb the port echoed by a reply in flight
                if (port_ok) port_q <= fric_inr[3:0];
            end
            if (rx_state == RX_ADR && !skip) begin
                for (int i = 0; i < ABYTES; i++)
                    if (rx_cnt == CW'(i)) addr[8*i +: 8] <= fric_inr;
            end
            if (rx_state == RX_WDAT && !skip) begin
                for (int i = 0; i < DBYTES; i++)
                    if (rx_cnt == CW'(i)) wdat[8*i +: 8] <= fric_inr;
            end
            rstb    <= start_rd;
            wr_done <= wdat_last && !skip;
            wstb    <= wr_done;
            drop    <= drop_nxt;
        end
    end

    assign busy = (rx_state != RX_IDLE) || !tx_idle;

    fric_slv_tx #(
        .ABYTES     (ABYTES),
        .DBYTES     (DBYTES),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_tx (
        .clk      (clk),
        .rst      (rst),
        .start_wr (start_wr),
        .start_rd (start_rd),
        .port     (port_q),
        .addr     (addr),
        .rdat     (rdat),
        .rvld     (rvld),
        .fric_out (fric_out),
        .tx_idle  (tx_idle)
    );

endmodule

// File: tb/tb_fric_client_slave_p.sv
// Scoreboard bench for fric_client_slave_p: one instance at ABYTES=1/DBYTES=2,
// one at ABYTES=2/DBYTES=4. Stimulus pushes expected (cycle, value) entries;
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_fric_client_slave_p;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  fric_in = 8'h00;
    logic [7:0]  fric_out;
    logic [7:0]  addr;
    logic [15:0] wdat;
    logic        wstb, rstb, busy, drop;
    logic [15:0] rdat = 16'h0;
    logic        rvld = 1'b0;

    logic [7:0]  fric_in2 = 8'h00;
    logic [7:0]  fric_out2;
    logic [15:0] addr2;
    logic [31:0] wdat2;
    logic        wstb2, rstb2, busy2, drop2;
    logic [31:0] rdat2 = 32'h0;
    logic        rvld2 = 1'b0;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t q_out[$], q_wstb[$], q_rstb[$], q_drop[$];
    exp_t q_out2[$], q_wstb2[$], q_rstb2[$];

    fric_client_slave_p #(.ABYTES(1), .DBYTES(2), .PORT_ID(4'h3), .RD_TIMEOUT(16)) u_dut (
        .clk(clk), .rst(rst), .fric_in(fric_in), .fric_out(fric_out), .addr(addr),
        .wdat(wdat), .wstb(wstb), .rstb(rstb), .rdat(rdat), .rvld(rvld),
        .busy(busy), .drop(drop)
    );

    fric_client_slave_p #(.ABYTES(2), .DBYTES(4), .PORT_ID(4'h2), .RD_TIMEOUT(16)) u_dut2 (
        .clk(clk), .rst(rst), .fric_in(fric_in2), .fric_out(fric_out2), .addr(addr2),
        .wdat(wdat2), .wstb(wstb2), .rstb(rstb2), .rdat(rdat2), .rvld(rvld2),
        .busy(busy2), .drop(drop2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc = c;
        e.a   = a;
        e.d   = d;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic [7:0] b);
        if (ch == 1) fric_in = b;
        else         fric_in2 = b;
        tick(1);
    endtask

    task automatic idle(input int n);
        fric_in  = 8'h00;
        fric_in2 = 8'h00;
        tick(n);
    endtask

    // Monitor: every visible output event must match the head of its queue
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (fric_out != 8'h00) begin
                if (q_out.size() == 0) check("out_unexpected", 32'(fric_out), 32'h0);
                else begin
                    e = q_out.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_byte", 32'(fric_out), e.d);
                end
            end
            if (wstb) begin
                if (q_wstb.size() == 0) check("wstb_unexpected", 32'(wstb), 32'h0);
                else begin
                    e = q_wstb.pop_front();
                    check("wstb_cycle", cyc, e.cyc);
                    check("wstb_addr", 32'(addr), e.a);
                    check("wstb_wdat", 32'(wdat), e.d);
                end
            end
            if (rstb) begin
                if (q_rstb.size() == 0) check("rstb_unexpected", 32'(rstb), 32'h0);
                else begin
                    e = q_rstb.pop_front();
                    check("rstb_cycle", cyc, e.cyc);
                    check("rstb_addr", 32'(addr), e.a);
                end
            end
            if (drop) begin
                if (q_drop.size() == 0) check("drop_unexpected", 32'(drop), 32'h0);
                else begin
                    e = q_drop.pop_front();
                    check("drop_cycle", cyc, e.cyc);
                end
            end
            if (fric_out2 != 8'h00) begin
                if (q_out2.size() == 0) check("out2_unexpected", 32'(fric_out2), 32'h0);
                else begin
                    e = q_out2.pop_front();
                    check("out2_cycle", cyc, e.cyc);
                    check("out2_byte", 32'(fric_out2), e.d);
                end
            end
            if (wstb2) begin
                if (q_wstb2.size() == 0) check("wstb2_unexpected", 32'(wstb2), 32'h0);
                else begin
                    e = q_wstb2.pop_front();
                    check("wstb2_cycle", cyc, e.cyc);
                    check("wstb2_addr", 32'(addr2), e.a);
                    check("wstb2_wdat", wdat2, e.d);
                end
            end
            if (rstb2) begin
                if (q_rstb2.size() == 0) check("rstb2_unexpected", 32'(rstb2), 32'h0);
                else begin
                    e = q_rstb2.pop_front();
                    check("rstb2_cycle", cyc, e.cyc);
                    check("rstb2_addr", 32'(addr2), e.a);
                end
            end
            if (drop2) check("drop2_unexpected", 32'(drop2), 32'h0);
        end
    end

    initial begin
        int c0;

        // Reset state
        tick(2);
        check("rst_fric_out", 32'(fric_out), 32'h0);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_wdat", 32'(wdat), 32'h0);
        check("rst_wstb", 32'(wstb), 32'h0);
        check("rst_rstb", 32'(rstb), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        rst = 1'b1;
        tick(2);

        // Write 0x23,0x10,0xCD,0xAB: ack 2 clks after the address byte, wstb after data
        c0 = cyc;
        q_out.push_back(mk(c0 + 3, 0, 32'h43));
        q_out.push_back(mk(c0 + 4, 0, 32'h10));
        q_wstb.push_back(mk(c0 + 6, 32'h10, 32'hABCD));
        send(1, 8'h23);
        send(1, 8'h10);
        check("wr_busy_mid", 32'(busy), 32'h1);
        send(1, 8'hCD);
        send(1, 8'hAB);
        idle(6);
        check("wr_busy_end", 32'(busy), 32'h0);

        // Read with rvld in the rstb cycle; a header decoded on the last reply byte is dropped
        c0 = cyc;
        q_rstb.push_back(mk(c0 + 3, 32'h10, 0));
        q_out.push_back(mk(c0 + 4, 0, 32'h53));
        q_out.push_back(mk(c0 + 5, 0, 32'h10));
        q_out.push_back(mk(c0 + 6, 0, 32'hEF));
        q_out.push_back(mk(c0 + 7, 0, 32'hBE));
        q_drop.push_back(mk(c0 + 8, 0, 0));
        send(1, 8'h33);
        send(1, 8'h10);
        idle(1);
        rvld = 1'b1;
        rdat = 16'hBEEF;
        tick(1);
        rvld = 1'b0;
        rdat = 16'h0;
        tick(2);
        send(1, 8'h33);
        idle(1);
        check("rd_out_idle", 32'(fric_out), 32'h0);
        check("rd_busy_end", 32'(busy), 32'h0);
        idle(3);

        // Read timeout: 16 RWAIT cycles then error reply; a late rvld is ignored
        c0 = cyc;
        q_rstb.push_back(mk(c0 + 3, 32'h20, 0));
        q_out.push_back(mk(c0 + 19, 0, 32'h73));
        q_out.push_back(mk(c0 + 20, 0, 32'h20));
        send(1, 8'h33);
        send(1, 8'h20);
        idle(20);
        rvld = 1'b1;
        rdat = 16'h1234;
        tick(1);
        rvld = 1'b0;
        tick(2);
        check("tmo_out_idle", 32'(fric_out), 32'h0);
        check("tmo_busy_end", 32'(busy), 32'h0);

        // rvld on the last allowed RWAIT cycle is still accepted
        c0 = cyc;
        q_rstb.push_back(mk(c0 + 3, 32'h21, 0));
        q_out.push_back(mk(c0 + 19, 0, 32'h53));
        q_out.push_back(mk(c0 + 20, 0, 32'h21));
        q_out.push_back(mk(c0 + 21, 0, 32'h34));
        q_out.push_back(mk(c0 + 22, 0, 32'h12));
        send(1, 8'h33);
        send(1, 8'h21);
        idle(16);
        rvld = 1'b1;
        rdat = 16'h1234;
        tick(1);
        rvld = 1'b0;
        idle(6);

        // Header 0x31 during RWAIT: drop once, no rstb, first reply intact
        c0 = cyc;
        q_rstb.push_back(mk(c0 + 3, 32'h30, 0));
`ifndef FRIC_SLV_PORT_FILTER_EN
        q_drop.push_back(mk(c0 + 7, 0, 0));
`endif
        q_out.push_back(mk(c0 + 10, 0, 32'h53));
        q_out.push_back(mk(c0 + 11, 0, 32'h30));
        q_out.push_back(mk(c0 + 12, 0, 32'hA5));
        q_out.push_back(mk(c0 + 13, 0, 32'h5A));
        send(1, 8'h33);
        send(1, 8'h30);
        idle(3);
        send(1, 8'h31);
        send(1, 8'h10);
        idle(2);
        rvld = 1'b1;
        rdat = 16'h5AA5;
        tick(1);
        rvld = 1'b0;
        idle(6);

        // Reset during the data phase of a write: outputs clear at once, no wstb later
        send(1, 8'h23);
        send(1, 8'h10);
        send(1, 8'hCD);
        fric_in = 8'hAB;
        #1;
        rst = 1'b0;
        #1;
        check("abort_fric_out", 32'(fric_out), 32'h0);
        check("abort_addr", 32'(addr), 32'h0);
        check("abort_wdat", 32'(wdat), 32'h0);
        check("abort_wstb", 32'(wstb), 32'h0);
        check("abort_rstb", 32'(rstb), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_drop", 32'(drop), 32'h0);
        tick(2);
        rst = 1'b1;
        idle(2);

        // Port 5 header: echoed in the ack, or skipped silently when filtering for port 3
        c0 = cyc;
`ifndef FRIC_SLV_PORT_FILTER_EN
        q_out.push_back(mk(c0 + 3, 0, 32'h45));
        q_out.push_back(mk(c0 + 4, 0, 32'h55));
        q_wstb.push_back(mk(c0 + 6, 32'h55, 32'h7766));
`endif
        send(1, 8'h25);
        send(1, 8'h55);
        send(1, 8'h66);
        send(1, 8'h77);
        idle(8);
        check("port_busy_end", 32'(busy), 32'h0);

        // ABYTES=2 DBYTES=4 write
        c0 = cyc;
        q_out2.push_back(mk(c0 + 4, 0, 32'h42));
        q_out2.push_back(mk(c0 + 5, 0, 32'h34));
        q_out2.push_back(mk(c0 + 6, 0, 32'h12));
        q_wstb2.push_back(mk(c0 + 9, 32'h1234, 32'h11223344));
        send(2, 8'h22);
        send(2, 8'h34);
        send(2, 8'h12);
        send(2, 8'h44);
        send(2, 8'h33);
        send(2, 8'h22);
        send(2, 8'h11);
        idle(8);

        // ABYTES=2 DBYTES=4 read with rvld in the rstb cycle
        c0 = cyc;
        q_rstb2.push_back(mk(c0 + 4, 32'h5678, 0));
        q_out2.push_back(mk(c0 + 5, 0, 32'h52));
        q_out2.push_back(mk(c0 + 6, 0, 32'h78));
        q_out2.push_back(mk(c0 + 7, 0, 32'h56));
        q_out2.push_back(mk(c0 + 8, 0, 32'h0D));
        q_out2.push_back(mk(c0 + 9, 0, 32'hF0));
        q_out2.push_back(mk(c0 + 10, 0, 32'hFE));
        q_out2.push_back(mk(c0 + 11, 0, 32'hCA));
        send(2, 8'h32);
        send(2, 8'h78);
        send(2, 8'h56);
        idle(1);
        rvld2 = 1'b1;
        rdat2 = 32'hCAFEF00D;
        tick(1);
        rvld2 = 1'b0;
        idle(10);
        check("dut2_busy_end", 32'(busy2), 32'h0);

        // Every expected event must have been observed
        check("left_out", q_out.size(), 0);
        check("left_wstb", q_wstb.size(), 0);
        check("left_rstb", q_rstb.size(), 0);
        check("left_drop", q_drop.size(), 0);
        check("left_out2", q_out2.size(), 0);
        check("left_wstb2", q_wstb2.size(), 0);
        check("left_rstb2", q_rstb2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
